// File: rtl/xs3_pkg.sv
// Shared constants and state encoding for the excess-3 decode path.
package xs3_pkg;

   localparam logic [3:0] XS3_OFFSET = 4'd3;
   localparam logic [3:0] XS3_MIN    = 4'h3;
   localparam logic [3:0] XS3_MAX    = 4'hC;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } xs3_state_t;

endpackage

// File: rtl/xs3_digit_decode.sv
// Single-digit excess-3 to BCD decode; illegal codes map to 0 and raise bad.
module xs3_digit_decode
   import xs3_pkg::*;
(
   input  logic [3:0] code,
   output logic [3:0] d,
   output logic       bad
);

   always_comb begin
      bad = (code < XS3_MIN) || (code > XS3_MAX);
      d   = bad ? 4'd0 : (code - XS3_OFFSET);
   end

endmodule

// File: rtl/xs3_to_binary_seq.sv
// Serial excess-3 digit stream (MSD first) to binary, with sticky error flag.
//
//   state | meaning
//   IDLE  | waiting for the first digit of a number
//   ACCUM | at least one digit taken, accumulating acc*10 + d
//   DONE  | result presented on out_*, waiting for out_ready
module xs3_to_binary_seq
   import xs3_pkg::*;
#(
   parameter int NDIGITS = 4,
   parameter int BIN_W   = 14,
   parameter int CNT_W   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_digit,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BIN_W-1:0] out_bin,
   output logic             out_err,
   output logic [CNT_W-1:0] out_ndigits
);

   xs3_state_t       state_q, state_d;
   logic [BIN_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             out_valid_q, out_valid_d;
   logic [BIN_W-1:0] out_bin_q, out_bin_d;
   logic             out_err_q, out_err_d;
   logic [CNT_W-1:0] out_ndigits_q, out_ndigits_d;

   logic [3:0] dig_d;
   logic       dig_bad;
   logic       accept;

   xs3_digit_decode u_dec (
      .code (in_digit),
      .d    (dig_d),
      .bad  (dig_bad)
   );

   assign in_ready = (state_q != DONE) && rst_n;
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               acc_d   = BIN_W'(dig_d);
               cnt_d   = CNT_W'(1);
               err_d   = dig_bad;
               state_d = (in_last || (NDIGITS == 1)) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               // x10 as shift-add; the BIN_W sizing rule means this never wraps
               acc_d   = (acc_q << 3) + (acc_q << 1) + BIN_W'(dig_d);
               cnt_d   = cnt_q + CNT_W'(1);
               err_d   = err_q | dig_bad;
               if (in_last || ((cnt_q + CNT_W'(1)) == CNT_W'(NDIGITS)))
                  state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
               acc_d   = '0;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
         end
      endcase

      // Outputs are loaded from next-state values so they appear with DONE.
      out_valid_d   = (state_d == DONE);
      out_bin_d     = out_valid_d ? acc_d : '0;
      out_err_d     = out_valid_d ? err_d : 1'b0;
      out_ndigits_d = out_valid_d ? cnt_d : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         acc_q         <= '0;
         cnt_q         <= '0;
         err_q         <= 1'b0;
         out_valid_q   <= 1'b0;
         out_bin_q     <= '0;
         out_err_q     <= 1'b0;
         out_ndigits_q <= '0;
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         cnt_q         <= cnt_d;
         err_q         <= err_d;
         out_valid_q   <= out_valid_d;
         out_bin_q     <= out_bin_d;
         out_err_q     <= out_err_d;
         out_ndigits_q <= out_ndigits_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_bin     = out_bin_q;
   assign out_err     = out_err_q;
   assign out_ndigits = out_ndigits_q;

endmodule

// File: tb/tb_xs3_to_binary_seq.sv
// Directed bench for xs3_to_binary_seq: hand-computed frames, reset and back-pressure cases.
module tb_xs3_to_binary_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_digit;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [13:0] out_bin;
   logic        out_err;
   logic [2:0]  out_ndigits;

   int vectors;
   int miscompares;

   xs3_to_binary_seq #(.NDIGITS(4), .BIN_W(14), .CNT_W(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_digit    (in_digit),
      .in_last     (in_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_bin     (out_bin),
      .out_err     (out_err),
      .out_ndigits (out_ndigits)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one digit and hold it until accepted; bounded wait on in_ready.
   task automatic send(input logic [3:0] code, input logic last);
      int n;
      in_valid = 1'b1;
      in_digit = code;
      in_last  = last;
      n = 0;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      if (!in_ready) check("send_ready_timeout", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_out(input string tag, input int bin, input int err, input int nd);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_bin"},   32'(out_bin),   32'(bin));
      check({tag, "_err"},   32'(out_err),   32'(err));
      check({tag, "_nd"},    32'(out_ndigits), 32'(nd));
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid0"}, 32'(out_valid), 32'd0);
      check({tag, "_bin0"},   32'(out_bin),   32'd0);
      check({tag, "_ready1"}, 32'(in_ready),  32'd1);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_digit    = 4'h0;
      in_last     = 1'b0;
      out_ready   = 1'b1;

      // Reset state
      step();
      step();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_valid",    32'(out_valid), 32'd0);
      check("rst_bin",      32'(out_bin), 32'd0);
      check("rst_err",      32'(out_err), 32'd0);
      check("rst_nd",       32'(out_ndigits), 32'd0);
      rst_n = 1'b1;
      step();
      check("post_rst_ready", 32'(in_ready), 32'd1);

      // 1: 4,5,6 -> 123, valid the cycle after the last digit
      send(4'h4, 1'b0);
      send(4'h5, 1'b0);
      send(4'h6, 1'b1);
      check_out("t1", 123, 0, 3);
      check("t1_in_ready_done", 32'(in_ready), 32'd0);
      step();
      check_idle("t1_after");

      // 2: four 4'hC, no in_last -> auto-terminate at 9999
      send(4'hC, 1'b0);
      send(4'hC, 1'b0);
      send(4'hC, 1'b0);
      check("t2_not_done_at_3", 32'(out_valid), 32'd0);
      send(4'hC, 1'b0);
      check_out("t2", 9999, 0, 4);
      step();
      check_idle("t2_after");

      // 3: illegal middle digit counts as 0 and sets err
      send(4'h4, 1'b0);
      send(4'hF, 1'b0);
      send(4'h5, 1'b1);
      check_out("t3", 102, 1, 3);
      step();
      check_idle("t3_after");

      // 4: back-pressure holds the result stable
      out_ready = 1'b0;
      send(4'h7, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check_out("t4_hold", 4, 0, 1);
         check("t4_in_ready", 32'(in_ready), 32'd0);
         step();
      end
      out_ready = 1'b1;
      check_out("t4_last_hold", 4, 0, 1);
      step();
      check_idle("t4_after");

      // 5: reset mid-frame discards the partial number
      send(4'h4, 1'b0);
      send(4'h4, 1'b0);
      rst_n = 1'b0;
      #1;
      check("t5_rst_ready", 32'(in_ready), 32'd0);
      check("t5_rst_valid", 32'(out_valid), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      check_idle("t5_after_rst");
      send(4'h3, 1'b1);
      check_out("t5", 0, 0, 1);
      step();
      check_idle("t5_after");

      // 6: in_valid held high across frames; digit offered in DONE is not taken
      in_valid = 1'b1;
      in_digit = 4'h5;
      in_last  = 1'b1;
      step();
      check_out("t6a", 2, 0, 1);
      in_digit = 4'h6;
      in_last  = 1'b1;
      check("t6_done_ready", 32'(in_ready), 32'd0);
      step();
      check("t6_idle_valid", 32'(out_valid), 32'd0);
      check("t6_idle_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      check_out("t6b", 3, 0, 1);
      step();
      check_idle("t6_after");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
